// File: rtl/text_pkg.sv
// Shared definitions for the character buffer: control codes, printable range,
// handshake FSM states and the cursor-advance rule.
// Ports: none (package only).
package text_pkg;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  // Unbounded next cursor position; the caller folds it into the buffer
  // (wrap or park). A newline jumps to the first cell of the next line.
  function automatic int cursor_adv(input int pos, input int cols, input logic newline);
    return newline ? ((pos | (cols - 1)) + 1) : (pos + 1);
  endfunction

endpackage

// File: rtl/text_buf_ram.sv
// Character cell store: DEPTH x WIDTH simple dual-port RAM, one synchronous write
// port and one registered read port (1-cycle latency, read-during-write returns old data).
// Ports: clk_i/rst_i, we_i/waddr_i/wdata_i write side, raddr_i/rdata_o read side.
module text_buf_ram #(
  parameter int              DEPTH   = 32,
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array itself carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= RST_VAL;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_buf.sv
// Character buffer between keyboard decoder and display: four-phase read_ready/read
// capture, cursor-based storage with BS/LF/FF handling, background clear sweep.
// Latency: ack 1 cycle after read_ready; capture on the edge read_ready is seen low.
// Backpressure: while busy (sweep) read stays low and read_ready simply waits.
// Ports: clk/rst, read_ready/char_in/read (decoder side), char_addr/char_out (display
// side), cursor/busy/full status.
module text_buf
  import text_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int COLS  = 16,
  parameter int WIDTH = 8,
  parameter int WRAP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_ready,
  input  logic [WIDTH-1:0]         char_in,
  output logic                     read,
  input  logic [$clog2(DEPTH)-1:0] char_addr,
  output logic [WIDTH-1:0]         char_out,
  output logic [$clog2(DEPTH)-1:0] cursor,
  output logic                     busy,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] SPACE = WIDTH'(CHAR_SPACE);

  state_t         state_q, state_d;
  logic [AW-1:0]  sweep_q, sweep_d;
  logic [AW-1:0]  cursor_q, cursor_d;
  logic           full_q, full_d;

  logic           capture;
  logic           is_print, is_bs, is_lf, is_ff;
  int             nxt;
  logic           hs_we;
  logic [AW-1:0]  hs_addr;
  logic [WIDTH-1:0] hs_dat;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_dat;

  assign is_print = (char_in >= WIDTH'(PRINT_LO)) && (char_in <= WIDTH'(PRINT_HI));
  assign is_bs    = (char_in == WIDTH'(CHAR_BS));
  assign is_lf    = (char_in == WIDTH'(CHAR_LF));
  assign is_ff    = (char_in == WIDTH'(CHAR_FF));
  assign capture  = (state_q == ST_ACK) && !read_ready;

  // FSM: state register. Reset lands in SWEEP so memory is initialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SWEEP;
    else     state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SWEEP: if (sweep_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      ST_IDLE:  if (read_ready) state_d = ST_ACK;
      ST_ACK:   if (!read_ready) state_d = is_ff ? ST_SWEEP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    read = (state_q == ST_ACK);
    busy = (state_q == ST_SWEEP);
  end

  // Cursor, full flag, sweep counter and the handshake-side write request.
  always_comb begin
    cursor_d = cursor_q;
    full_d   = full_q;
    sweep_d  = sweep_q;
    hs_we    = 1'b0;
    hs_addr  = cursor_q;
    hs_dat   = char_in;
    nxt      = cursor_adv(int'(cursor_q), COLS, is_lf);
    // Counter naturally rolls back to 0 after the last cell.
    if (state_q == ST_SWEEP) sweep_d = sweep_q + AW'(1);
    if (capture) begin
      if (is_print || is_lf) begin
        // A parked cursor drops printables and newlines silently.
        if (!full_q) begin
          hs_we = is_print;
          if (nxt >= DEPTH && WRAP == 0) begin
            full_d   = 1'b1;
            cursor_d = AW'(DEPTH - 1);
          end else begin
            // DEPTH is a power of two, so truncation is the modulo wrap.
            cursor_d = AW'(nxt);
          end
        end
      end else if (is_bs) begin
        if (full_q) begin
          // Cursor already sits on the last cell; just unpark and blank it.
          full_d = 1'b0;
          hs_we  = 1'b1;
          hs_dat = SPACE;
        end else if (cursor_q != '0) begin
          cursor_d = cursor_q - AW'(1);
          hs_we    = 1'b1;
          hs_addr  = cursor_q - AW'(1);
          hs_dat   = SPACE;
        end
      end else if (is_ff) begin
        cursor_d = '0;
        full_d   = 1'b0;
        sweep_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_q  <= '0;
      cursor_q <= '0;
      full_q   <= 1'b0;
    end else begin
      sweep_q  <= sweep_d;
      cursor_q <= cursor_d;
      full_q   <= full_d;
    end
  end

  // Sweep owns the write port whenever it runs.
  assign ram_we   = busy | hs_we;
  assign ram_addr = busy ? sweep_q : hs_addr;
  assign ram_dat  = busy ? SPACE : hs_dat;

  text_buf_ram #(
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .RST_VAL (SPACE)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (ram_addr),
    .wdata_i (ram_dat),
    .raddr_i (char_addr),
    .rdata_o (char_out)
  );

  assign cursor = cursor_q;
  assign full   = full_q;

endmodule

// File: tb/tb_text_buf.sv
module tb_text_buf;

  localparam int DEPTH = 32;
  localparam int COLS  = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            read_ready;
  logic [WIDTH-1:0] char_in;
  logic [AW-1:0]   char_addr;

  logic            read_w, busy_w, full_w;
  logic [WIDTH-1:0] char_out_w;
  logic [AW-1:0]   cursor_w;
  logic            read_n, busy_n, full_n;
  logic [WIDTH-1:0] char_out_n;
  logic [AW-1:0]   cursor_n;

  always #5 clk = ~clk;

  text_buf #(.DEPTH(DEPTH), .COLS(COLS), .WIDTH(WIDTH), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .read_ready(read_ready), .char_in(char_in), .read(read_w),
    .char_addr(char_addr), .char_out(char_out_w), .cursor(cursor_w), .busy(busy_w), .full(full_w)
  );

  text_buf #(.DEPTH(DEPTH), .COLS(COLS), .WIDTH(WIDTH), .WRAP(0)) dut_n (
    .clk(clk), .rst(rst), .read_ready(read_ready), .char_in(char_in), .read(read_n),
    .char_addr(char_addr), .char_out(char_out_n), .cursor(cursor_n), .busy(busy_n), .full(full_n)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 = wrapping buffer, index 1 = parking buffer.
  byte unsigned mem_m [2][DEPTH];
  int           cur_m [2];
  bit           full_m[2];

  byte unsigned c;
  int           r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < DEPTH; a++) mem_m[k][a] = 8'h20;
      cur_m[k]  = 0;
      full_m[k] = 1'b0;
    end
  endfunction

  function automatic void model_move(int k, int target);
    if (target >= DEPTH) begin
      if (k == 0) cur_m[k] = target % DEPTH;
      else begin
        cur_m[k]  = DEPTH - 1;
        full_m[k] = 1'b1;
      end
    end else cur_m[k] = target;
  endfunction

  function automatic void model_char(byte unsigned ch);
    if (ch == 8'h0C) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        if (!full_m[k]) begin
          mem_m[k][cur_m[k]] = ch;
          model_move(k, cur_m[k] + 1);
        end
      end else if (ch == 8'h0A) begin
        if (!full_m[k]) model_move(k, (cur_m[k] / COLS + 1) * COLS);
      end else if (ch == 8'h08) begin
        if (full_m[k]) begin
          full_m[k] = 1'b0;
          mem_m[k][DEPTH-1] = 8'h20;
        end else if (cur_m[k] > 0) begin
          cur_m[k] = cur_m[k] - 1;
          mem_m[k][cur_m[k]] = 8'h20;
        end
      end
    end
  endfunction

  // Called #1 after a rising edge with the buffer idle.
  task automatic send(input byte unsigned ch);
    chk("idle_before_send", {30'b0, busy_w, busy_n}, 32'd0);
    char_in    = ch;
    read_ready = 1'b1;
    @(posedge clk); #1;
    chk("ack_w", {31'b0, read_w}, 32'd1);
    chk("ack_n", {31'b0, read_n}, 32'd1);
    read_ready = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop_w", {31'b0, read_w}, 32'd0);
    chk("ack_drop_n", {31'b0, read_n}, 32'd0);
    model_char(ch);
    char_in = 8'h00;
  endtask

  // Counts edges until busy falls; read must stay low the whole time.
  task automatic wait_sweep();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy_w || busy_n) begin
        chk("read_low_in_sweep_w", {31'b0, read_w}, 32'd0);
        chk("read_low_in_sweep_n", {31'b0, read_n}, 32'd0);
      end
    end while ((busy_w || busy_n) && n < 200);
    chk("sweep_len", n, DEPTH);
    chk("sweep_end_busy", {30'b0, busy_w, busy_n}, 32'd0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_cursor_w"}, {27'b0, cursor_w}, cur_m[0]);
    chk({tag, "_cursor_n"}, {27'b0, cursor_n}, cur_m[1]);
    chk({tag, "_full_w"}, {31'b0, full_w}, {31'b0, full_m[0]});
    chk({tag, "_full_n"}, {31'b0, full_n}, {31'b0, full_m[1]});
  endtask

  task automatic check_cells(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      char_addr = AW'(a);
      @(posedge clk); #1;
      chk({tag, "_cell_w"}, {24'b0, char_out_w}, {24'b0, mem_m[0][a]});
      chk({tag, "_cell_n"}, {24'b0, char_out_n}, {24'b0, mem_m[1][a]});
    end
  endtask

  // Completes a handshake whose read_ready was raised while busy.
  task automatic finish_pending(input byte unsigned ch);
    chk("pending_not_yet", {30'b0, read_w, read_n}, 32'd0);
    @(posedge clk); #1;
    chk("pending_ack", {30'b0, read_w, read_n}, 32'd3);
    read_ready = 1'b0;
    @(posedge clk); #1;
    chk("pending_drop", {30'b0, read_w, read_n}, 32'd0);
    model_char(ch);
  endtask

  initial begin
    rst        = 1'b1;
    read_ready = 1'b0;
    char_in    = '0;
    char_addr  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {30'b0, busy_w, busy_n}, 32'd3);
    chk("rst_read", {30'b0, read_w, read_n}, 32'd0);
    chk("rst_char_out_w", {24'b0, char_out_w}, 32'h20);
    chk("rst_char_out_n", {24'b0, char_out_n}, 32'h20);
    check_status("rst");

    // Power-up sweep.
    rst = 1'b0;
    wait_sweep();
    check_cells("init");

    // "AB", backspace, "C".
    send(8'h41); send(8'h42); send(8'h08); send(8'h43);
    check_status("abc");
    chk("abc_cursor_const", {27'b0, cursor_w}, 32'd2);
    check_cells("abc");

    // Newline from cursor 3, then 'X'.
    send(8'h78);
    send(8'h0A);
    send(8'h58);
    chk("lf_cursor_const", {27'b0, cursor_w}, 32'd17);
    check_status("lf");
    check_cells("lf");

    // Form feed, then 33 printables to hit the end of the buffer.
    send(8'h0C);
    wait_sweep();
    check_status("ff");
    for (int i = 0; i < 33; i++) send(8'(8'h61 + (i % 26)));
    chk("wrap_cursor_const", {27'b0, cursor_w}, 32'd1);
    chk("park_cursor_const", {27'b0, cursor_n}, 32'd31);
    chk("park_full_const", {31'b0, full_n}, 32'd1);
    check_status("end");
    check_cells("end");
    send(8'h08);
    chk("bs_unpark_const", {31'b0, full_n}, 32'd0);
    check_status("bs_end");
    check_cells("bs_end");

    // Randomised character stream (no form feed).
    send(8'h0C);
    wait_sweep();
    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      c = 8'($urandom_range(32, 126));
      else if (r == 6) c = 8'h08;
      else if (r == 7) c = 8'h0A;
      else if (r == 8) begin
        c = 8'($urandom_range(0, 31));
        if (c == 8'h08 || c == 8'h0A || c == 8'h0C) c = 8'h7F;
      end else c = 8'($urandom_range(127, 255));
      send(c);
      check_status("rand");
    end
    check_cells("rand");

    // read_ready raised during a form-feed sweep waits for busy to fall.
    send(8'h0C);
    char_in    = 8'h51;
    read_ready = 1'b1;
    wait_sweep();
    finish_pending(8'h51);
    check_status("pend");
    check_cells("pend");

    // Reset in the middle of a sweep with a handshake pending.
    send(8'h0C);
    char_in    = 8'h5A;
    read_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {30'b0, busy_w, busy_n}, 32'd3);
    chk("midrst_read", {30'b0, read_w, read_n}, 32'd0);
    model_clear();
    check_status("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_sweep();
    finish_pending(8'h5A);
    check_status("after_rst");
    check_cells("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_buf.md
# text_buf

Parametrised character buffer between the keyboard decoder and the text display. It accepts characters over the decoder's four-phase read_ready/read handshake and stores printable characters at a cursor. It interprets backspace, newline and form-feed control codes and clears itself with a background sweep. The display reads any cell through a registered random-access port.

## Interface
- DEPTH, 32: number of character cells; power of two, at least 4.
- COLS, 16: cells per display line; power of two, divides DEPTH.
- WIDTH, 8: character width in bits.
- WRAP, 1: 1 = cursor wraps from DEPTH-1 to 0; 0 = cursor stops at the end and further printable characters are dropped.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_ready  input  1  decoder has a character valid on char_in.
- char_in  input  WIDTH  character from the decoder; stable while read_ready is high.
- read  output  1  acknowledge to the decoder; reset 0.
- char_addr  input  log2(DEPTH)  display read address.
- char_out  output  WIDTH  registered cell contents; reset 8'h20.
- cursor  output  log2(DEPTH)  next write position; reset 0.
- busy  output  1  clear sweep in progress; reset 1.
- full  output  1  WRAP=0 only: cursor is parked past the last cell; reset 0.

## Operation
- Handshake: read rises on the first edge at which read_ready=1, read=0 and busy=0.
- Capture: on the first edge with read=1 and read_ready=0, the block does all of the following on that same edge:
  - drops read to 0;
  - latches the char_in value sampled at that edge;
  - processes the character.
- The decoder holds char_in until read_ready falls.
- While busy=1, read stays 0 and a pending read_ready simply waits.
- Character processing, with p = cursor:
  - Printable character (0x20..0x7E): write mem[p]; cursor = p+1.
  - Backspace 0x08, p>0: cursor = p-1; write 0x20 at p-1.
  - Backspace 0x08, p=0: no-op.
  - Newline 0x0A: cursor = (p | (COLS-1)) + 1, i.e. the start of the next line.
  - Form feed 0x0C: start a clear sweep; cursor = 0.
  - Any other code: discarded; cursor unchanged.
- End-of-buffer rules:
  - WRAP=1: cursor arithmetic is modulo DEPTH.
  - WRAP=0: any advance beyond DEPTH-1 sets full=1 and holds cursor at DEPTH-1.
  - WRAP=0, full=1: printable characters and newlines are acknowledged and dropped.
  - Backspace clears full and writes 0x20 at DEPTH-1; cursor stays DEPTH-1.
- Clear sweep:
  - On reset release or on form feed, a sweep counter writes 0x20 to cells 0..DEPTH-1, one per cycle.
  - busy=1 for exactly DEPTH cycles; busy falls on the edge that writes cell DEPTH-1.
  - full and cursor are cleared at sweep start.
- Reset mid-sweep or mid-handshake:
  - all registers return to their reset values;
  - the sweep restarts from cell 0;
  - a half-completed handshake is abandoned with read=0.
- Memory contents are not reset directly; the sweep alone initialises them.

## Timing
- Ack latency: read rises 1 cycle after read_ready is first sampled high (busy=0).
- Write latency: a cell written at capture edge N is visible on char_out when addressed at edge N+1 or later.
- Read port: char_out = mem[char_addr] registered, 1-cycle latency.
- Read-during-write to the same cell returns the old data.
- The display read port is unaffected by handshake or sweep activity, apart from the contents read.
- Minimum handshake period is 3 cycles: ready high, ack, ready low/capture.
- One character per handshake.

## Structure
- Shared package text_pkg holds:
  - control-code constants CHAR_BS=8'h08, CHAR_LF=8'h0A, CHAR_FF=8'h0C, CHAR_SPACE=8'h20;
  - the printable-range bounds;
  - the cursor-advance function.
- One sub-module, text_buf_ram: a DEPTH x WIDTH simple dual-port RAM with one synchronous write port and one registered read port. It infers block or distributed RAM.
- The write port is muxed between the sweep counter and the handshake path; the sweep has priority.
- The top level holds the handshake FSM (IDLE, ACK, SWEEP), the cursor and the full flag.

## Test plan
- Reset, then read all cells after busy falls:
  - busy is high for DEPTH cycles after reset release;
  - every cell returns 0x20;
  - read was never asserted during the sweep.
- Send "AB", then 0x08, then "C":
  - cells 0,1 = 'A','C';
  - cell 2 = 0x20;
  - cursor = 2;
  - read pulses once per character, rising 1 cycle after read_ready.
- COLS=16, cursor=3, send 0x0A then 'X': cell 16 = 'X'; cursor = 17.
- WRAP=1, DEPTH=32: 33 printable characters 'a'.. leave cell 0 holding the 33rd character and cursor = 1.
- WRAP=0:
  - 33 characters leave cell 31 = 32nd character, full=1, cursor=31, and the 33rd character acknowledged but not stored;
  - a following 0x08 clears full and leaves cell 31 = 0x20.
- Raise read_ready during a form-feed sweep:
  - read stays low until busy falls, then acks;
  - asserting rst mid-sweep restarts the sweep from cell 0 with read=0.
